mod3_reduce_pipe: RTL

MOD3_REDUCE_PIPE -- requirements
Module: mod3_reduce_pipe

---
 rtl/mod3_pkg.sv | 49 ++++
 rtl/mod3_lane.sv | 45 ++++
 rtl/mod3_reduce_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/mod3_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod3_pkg : residue encodings and 2-bit modulo-3 arithmetic helpers
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
package mod3_pkg;

  localparam logic [1:0] RES_ZERO = 2'b00;
  localparam logic [1:0] RES_ONE  = 2'b01;
  localparam logic [1:0] RES_TWO  = 2'b10;
  localparam logic [1:0] RES_NEG1 = 2'b11;

  function automatic int num_nib(input int w);
    return (w + 3) / 4;
  endfunction

  // 16 == 1 (mod 3), so a nibble's residue adds directly into the total.
  function automatic logic [1:0] nib_res(input logic [3:0] n);
    case (n)
      4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: return RES_ZERO;
      4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       return RES_ONE;
      default:                              return RES_TWO;
    endcase
  endfunction

  function automatic logic [1:0] res_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] res_sub(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] nb;
    nb = (b == RES_ZERO) ? RES_ZERO : (2'd3 - b);
    return res_add(a, nb);
  endfunction

  // 2^W mod 3: 1 for even W, 2 for odd W.
  function automatic logic [1:0] msb_corr(input int w);
    return (w % 2 == 0) ? RES_ONE : RES_TWO;
  endfunction

  function automatic logic [1:0] res_encode(input logic [1:0] r, input logic centered);
    return (centered && r == RES_TWO) ? RES_NEG1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod3_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod3_lane : combinational per-lane nibble reduction and residue combine tree
// Rev 1.0   : initial release
// ----------------------------------------------------------------------------
module mod3_lane
  import mod3_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]               data_i,
  input  logic                       signed_i,
  output logic [2*((W+3)/4)-1:0]     parts_o,
  output logic [1:0]                 corr_o,
  input  logic [2*((W+3)/4)-1:0]     parts_i,
  input  logic [1:0]                 corr_i,
  input  logic                       centered_i,
  output logic [1:0]                 res_o
);

  localparam int NNIB = num_nib(W);

  always_comb begin : p_nibbles
    logic [4*NNIB-1:0] ext;
    ext          = '0;
    ext[W-1:0]   = data_i;
    parts_o      = '0;
    for (int n = 0; n < NNIB; n++) begin
      parts_o[2*n +: 2] = nib_res(ext[4*n +: 4]);
    end
  end

  assign corr_o = (signed_i && data_i[W-1]) ? msb_corr(W) : RES_ZERO;

  // Heap-ordered tree: leaves at NNIB..2*NNIB-1, root at index 1.
  always_comb begin : p_tree
    logic [1:0] node [1:2*NNIB-1];
    for (int i = 1; i < 2*NNIB; i++) node[i] = RES_ZERO;
    for (int n = 0; n < NNIB; n++) node[NNIB+n] = parts_i[2*n +: 2];
    for (int i = NNIB - 1; i >= 1; i--) node[i] = res_add(node[2*i], node[2*i+1]);
    res_o = res_encode(res_sub(node[1], corr_i), centered_i);
  end

endmodule
`default_nettype wire

// File: rtl/mod3_reduce_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod3_reduce_pipe : two-stage valid/ready pipeline reducing LANES coefficients mod 3
// Rev 1.0          : initial release
// ----------------------------------------------------------------------------
module mod3_reduce_pipe
  import mod3_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic                 in_signed,
  input  logic                 in_centered,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LANES-1:0]   out_res
);

  localparam int NNIB = num_nib(W);
  localparam int PW   = 2 * NNIB;

  logic                  s1_valid_q,    s1_valid_d;
  logic [LANES*PW-1:0]   s1_parts_q,    s1_parts_d;
  logic [2*LANES-1:0]    s1_corr_q,     s1_corr_d;
  logic                  s1_centered_q, s1_centered_d;
  logic                  s2_valid_q,    s2_valid_d;
  logic [2*LANES-1:0]    s2_res_q,      s2_res_d;

  logic [LANES*PW-1:0]   lane_parts;
  logic [2*LANES-1:0]    lane_corr;
  logic [2*LANES-1:0]    lane_res;
  logic                  s2_adv, s2_load, s1_adv, in_acc;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod3_lane #(.W(W)) u_lane (
      .data_i     (in_data[k*W +: W]),
      .signed_i   (in_signed),
      .parts_o    (lane_parts[k*PW +: PW]),
      .corr_o     (lane_corr[2*k +: 2]),
      .parts_i    (s1_parts_q[k*PW +: PW]),
      .corr_i     (s1_corr_q[2*k +: 2]),
      .centered_i (s1_centered_q),
      .res_o      (lane_res[2*k +: 2])
    );
  end

  // in_ready depends only on stage state and out_ready, never on in_valid.
  assign s2_adv   = s2_valid_q & out_ready;
  assign s2_load  = ~s2_valid_q | s2_adv;
  assign s1_adv   = s1_valid_q & s2_load;
  assign in_ready = ~s1_valid_q | s1_adv;
  assign in_acc   = in_valid & in_ready;

  always_comb begin
    s1_valid_d    = in_ready ? in_valid : s1_valid_q;
    s1_parts_d    = in_acc ? lane_parts  : s1_parts_q;
    s1_corr_d     = in_acc ? lane_corr   : s1_corr_q;
    s1_centered_d = in_acc ? in_centered : s1_centered_q;
    s2_valid_d    = s2_load ? s1_valid_q : s2_valid_q;
    s2_res_d      = s1_adv ? lane_res : s2_res_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_parts_q    <= '0;
      s1_corr_q     <= '0;
      s1_centered_q <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_res_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_parts_q    <= s1_parts_d;
      s1_corr_q     <= s1_corr_d;
      s1_centered_q <= s1_centered_d;
      s2_valid_q    <= s2_valid_d;
      s2_res_q      <= s2_res_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_valid_q ? s2_res_q : '0;

endmodule
`default_nettype wire
